// File: rtl/mux_demux_pkg.sv
// Shared definitions for the 4:1 collector and the 1:4 demux: channel select
// codes, the collector's output-register state and the index->code mapping.
package mux_demux_pkg;

  localparam int unsigned NUM_CH = 4;

  localparam logic [1:0] SEL_CH0 = 2'b11;
  localparam logic [1:0] SEL_CH1 = 2'b01;
  localparam logic [1:0] SEL_CH2 = 2'b10;
  localparam logic [1:0] SEL_CH3 = 2'b00;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } mux_state_e;

  // Bit 0 of the code drives demux input_sel[0], bit 1 drives input_sel[1].
  function automatic logic [1:0] ch_to_sel(input logic [1:0] ch);
    logic [1:0] code;
    unique case (ch)
      2'd0:    code = SEL_CH0;
      2'd1:    code = SEL_CH1;
      2'd2:    code = SEL_CH2;
      default: code = SEL_CH3;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/modulo_arb4.sv
// Four-way request arbiter: one-hot grant plus encoded index.
// MUX_ROUND_ROBIN_EN selects round-robin from last_i+1; otherwise ch0 highest priority.
module modulo_arb4
  import mux_demux_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  input  logic       en_i,
  output logic [3:0] gnt_o,
  output logic [1:0] idx_o
);

  logic       found;
  logic [1:0] idx;
  logic [1:0] cand;

`ifdef MUX_ROUND_ROBIN_EN
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = last_i + 2'(k);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
`else
  logic [1:0] unused_last;
  assign unused_last = last_i;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = 2'(k);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
`endif

  assign gnt_o = (en_i && found) ? (4'b0001 << idx) : '0;
  assign idx_o = idx;

endmodule

// File: rtl/modulo_mux4_1_arb.sv
// Four-channel to one collector with a single-entry registered output tagged by
// source select code. Arbitration mode set by MUX_ROUND_ROBIN_EN inside modulo_arb4.
module modulo_mux4_1_arb
  import mux_demux_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            in_valid,
  input  logic [4*DATA_W-1:0]   in_data,
  output logic [3:0]            in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_sel
);

  mux_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        last_q, last_d;
  logic              can_accept;
  logic [3:0]        gnt;
  logic [1:0]        gnt_idx;
  logic              fire;

  // rst_n gates acceptance so no in_ready pulse escapes while reset is held.
  assign can_accept = rst_n && ((state_q == ST_EMPTY) || out_ready);

  modulo_arb4 u_arb (
    .req_i  (in_valid),
    .last_i (last_q),
    .en_i   (can_accept),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );

  assign fire     = |gnt;
  assign in_ready = gnt;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (fire) begin
      state_d = ST_FULL;
      data_d  = in_data[gnt_idx*DATA_W +: DATA_W];
      sel_d   = ch_to_sel(gnt_idx);
      last_d  = gnt_idx;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= 2'b00;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule
